// File: rtl/wc_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : wc_tile_feeder
// Purpose  : Upstream stage of the Winograd F(3,5) core. Collects a serial
//            stream of DW-bit signed samples into TAPS-sample overlapping
//            tiles (stride STRIDE) and presents each tile on D with a
//            valid/ready handshake and end-of-row zero padding.
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous reset, active low
//            s_data   - input sample (two's complement)
//            s_valid  - s_data valid
//            s_last   - s_data is the final sample of a row
//            s_ready  - feeder accepts a sample this cycle
//            D        - tile, oldest sample in the top lane, newest in [DW-1:0]
//            d_valid  - D holds a complete tile
//            d_last   - current tile closes the row
//            d_ready  - consumer accepts the tile
// Options  : WC_FEEDER_HOLD_EN - freeze D and stall input for HOLD cycles
//            after every tile handshake.
// Revision : 1.0 - initial release
// ============================================================================
module wc_tile_feeder #(
  parameter int DW     = 10,
  parameter int TAPS   = 7,
`ifdef WC_FEEDER_HOLD_EN
  parameter int HOLD   = 6,
`endif
  parameter int STRIDE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [TAPS*DW-1:0]   D,
  output logic                 d_valid,
  output logic                 d_last,
  input  logic                 d_ready
);

  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] C_TAPS   = CW'(TAPS);
  localparam logic [CW-1:0] C_STRIDE = CW'(STRIDE);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_PAD   = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  state_t              r_state, state_n;
  logic [CW-1:0]       r_cnt, cnt_n;
  logic [TAPS*DW-1:0]  r_window, window_n;
  logic                r_last, last_n;
  logic                r_full, full_n;   // current tile needs a full TAPS fill
  logic                r_ready, ready_n;
  logic                w_accept;
  logic                w_handshake;
  logic                w_hold_busy;
  logic [CW-1:0]       w_target;

  assign w_accept    = s_valid & r_ready;
  assign w_handshake = (r_state == ST_EMIT) & d_ready;
  assign w_target    = r_full ? C_TAPS : C_STRIDE;

  always_comb begin
    state_n  = r_state;
    cnt_n    = r_cnt;
    window_n = r_window;
    last_n   = r_last;
    full_n   = r_full;
    case (r_state)
      ST_FILL, ST_SLIDE: begin
        if (w_accept) begin
          window_n = {r_window[(TAPS-1)*DW-1:0], s_data};
          cnt_n    = r_cnt + 1'b1;
          if (cnt_n == w_target) begin
            // s_last on the completing sample closes the row with no padding
            state_n = ST_EMIT;
            last_n  = s_last;
          end else if (s_last) begin
            state_n = ST_PAD;
            last_n  = 1'b1;
          end
        end
      end
      ST_PAD: begin
        window_n = {r_window[(TAPS-1)*DW-1:0], {DW{1'b0}}};
        cnt_n    = r_cnt + 1'b1;
        if (cnt_n == w_target) begin
          state_n = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (d_ready) begin
          // Window is left as is: its newest TAPS-STRIDE lanes seed the next tile
          cnt_n   = '0;
          last_n  = 1'b0;
          full_n  = r_last;
          state_n = r_last ? ST_FILL : ST_SLIDE;
        end
      end
      default: begin
        state_n = ST_FILL;
      end
    endcase
  end

`ifdef WC_FEEDER_HOLD_EN
  localparam int HW = $clog2(HOLD + 1);
  logic [HW-1:0] r_hold, hold_n;

  always_comb begin
    hold_n = r_hold;
    if (w_handshake) begin
      hold_n = HW'(HOLD);
    end else if (r_hold != '0) begin
      hold_n = r_hold - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else begin
      r_hold <= hold_n;
    end
  end

  assign w_hold_busy = (hold_n != '0);
`else
  assign w_hold_busy = 1'b0;
`endif

  // s_ready is registered from the next state so it is low on the first
  // cycle after reset and rises exactly one cycle after a handshake.
  assign ready_n = ((state_n == ST_FILL) || (state_n == ST_SLIDE)) && !w_hold_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_FILL;
      r_cnt    <= '0;
      r_window <= '0;
      r_last   <= 1'b0;
      r_full   <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= state_n;
      r_cnt    <= cnt_n;
      r_window <= window_n;
      r_last   <= last_n;
      r_full   <= full_n;
      r_ready  <= ready_n;
    end
  end

  assign s_ready = r_ready;
  assign D       = r_window;
  assign d_valid = (r_state == ST_EMIT);
  assign d_last  = r_last;

endmodule
`default_nettype wire

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Upstream stage of the Winograd F(3,5) core `wc`.
- Accepts a serial stream of 10-bit signed samples and assembles them into 7-sample overlapping tiles with stride 3 (overlap 4).
- Presents each tile on the 70-bit `D` bus the core consumes, with a valid/ready handshake and end-of-row handling.

Parameters:
- DW, 10, sample width in bits (two's complement).
- TAPS, 7, tile length in samples (m + r - 1 for F(3,5)).
- STRIDE, 3, new samples per tile after the first (m).
- HOLD, 6, minimum cycles a tile is held stable after acceptance (optional feature only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  DW  input sample.
- s_valid  in  1  s_data valid.
- s_last  in  1  qualifies s_data as the final sample of a row.
- s_ready  out  1  feeder can accept a sample this cycle.
- D  out  TAPS*DW  tile to the core; oldest sample in D[69:60], newest in D[9:0].
- d_valid  out  1  D holds a complete tile.
- d_last  out  1  current tile closes the row.
- d_ready  in  1  consumer accepts the tile.

Behaviour:
- Reset (rst=0, asynchronous):
  - window registers = 0, D = 0, d_valid = 0, d_last = 0, s_ready = 0.
  - state = FILL, fill count = 0.
  - The first edge after deassertion sets s_ready = 1.
  - Reset asserted mid-tile discards all partial data; no tile is emitted.
- Sample transfer occurs when s_valid & s_ready on a rising edge. The sample shifts into the window at the newest position; all lanes shift toward the oldest position.
- States:
  - FILL: s_ready = 1; counts accepted samples 0..7.
    - On the 7th accept → EMIT.
    - s_last accepted with count < 7 → PAD.
  - SLIDE: s_ready = 1; counts new samples 0..3.
    - On the 3rd accept → EMIT.
    - s_last accepted with count < 3 → PAD.
  - PAD: s_ready = 0; shifts in one zero sample per cycle until the FILL target (7) or SLIDE target (3) is reached → EMIT. d_last is set.
  - EMIT: s_ready = 0, d_valid = 1; D and d_last stable until d_ready.
    - Handshake is d_valid & d_ready: d_valid drops the next cycle.
    - If d_last = 0 → SLIDE (the 4 newest samples are retained as the next tile's oldest 4).
    - If d_last = 1 → FILL with count cleared and d_last cleared.
- Tile with s_last on exactly the completing sample: → EMIT directly with d_last = 1, no PAD cycles.
- Latency:
  - d_valid rises the cycle after the completing sample is accepted.
  - s_ready reasserts the cycle after the tile handshake.
- d_valid must never drop, and D must never change, while d_ready = 0.
- Arithmetic: no arithmetic. Samples pass bit-exact; pad value is all-zero.
- s_valid while s_ready = 0: ignored, no data loss inside the feeder. The producer must hold its data.

Optional Feature:
- Macro WC_FEEDER_HOLD_EN.
- Defined:
  - After each tile handshake, D stays frozen for HOLD cycles, counted from the handshake edge.
  - s_ready stays 0 during this window, so D is stable for the core's 6-cycle compute latency.
  - d_valid is 0 during the hold.
  - The next tile's d_valid cannot rise before hold expiry + the remaining samples.
- Undefined:
  - No hold counter.
  - s_ready reasserts the cycle after the handshake.
  - D updates as soon as new samples shift in.

Test Plan:
- Fill and tile emit: reset, then stream 2,-10,3,4,-13,-18,-16 with d_ready=1 → d_valid=1 one cycle after the 7th accept, with:
  - D = 0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000
  - d_last = 0.
- Slide: continue with -19,-6,3 → second tile D lanes = [4,-13,-18,-16,-19,-6,3] oldest→newest, emitted after exactly 3 accepts.
- Backpressure: hold d_ready=0 for 10 cycles during EMIT → D, d_valid and d_last constant, s_ready=0 throughout, and the tile is released on the first d_ready=1.
- End of row with padding: FILL with 1,2,3,4 and s_last on 4 → three PAD cycles, then tile [1,2,3,4,0,0,0] with d_last=1. The next sample starts a fresh FILL (count 0).
- Reset mid-operation: rst=0 after 5 accepts → D=0, d_valid=0, s_ready=0 immediately (asynchronous). After release, 7 new samples are needed for the first tile.
- With WC_FEEDER_HOLD_EN: back-to-back samples → D unchanged for 6 cycles after each handshake, and s_ready=0 in those cycles.
